// File: rtl/mini16sc_mem_responder_pkg.sv
// Shared definitions for the mini16sc memory responder: FSM encoding,
// reserved IO addresses and status-word bit positions.
package mini16sc_mem_pkg;

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_LOAD    = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  localparam int STAT_OVF  = 15;
  localparam int STAT_FULL = 14;

  // The two IO words occupy the top of the data address space.
  function automatic logic [31:0] io_tx_off(input int unsigned depth);
    return (32'd1 << depth) - 32'd1;
  endfunction

  function automatic logic [31:0] io_stat_off(input int unsigned depth);
    return (32'd1 << depth) - 32'd2;
  endfunction

endpackage

// File: rtl/mini16sc_mem_responder_if.sv
// CPU/host/stream bus of the memory responder. The responder takes the slave
// modport; whoever drives the CPU, host loader and stream sink takes master.
interface mini16sc_mem_if #(
  parameter int WIDTH_I = 16,
  parameter int WIDTH_D = 16,
  parameter int DEPTH_I = 8,
  parameter int DEPTH_D = 8
);
  logic [DEPTH_I-1:0] mem_i_r_addr;
  logic [WIDTH_I-1:0] mem_i_r_data;
  logic [DEPTH_D-1:0] mem_d_r_addr;
  logic [WIDTH_D-1:0] mem_d_r_data;
  logic [DEPTH_D-1:0] mem_d_w_addr;
  logic [WIDTH_D-1:0] mem_d_w_data;
  logic               mem_d_we;
  logic               soft_reset;
  logic               load_start;
  logic               load_valid;
  logic [WIDTH_I-1:0] load_data;
  logic               load_last;
  logic               load_ready;
  logic               out_valid;
  logic [WIDTH_D-1:0] out_data;
  logic               out_ready;

  modport slave (
    input  mem_i_r_addr, mem_d_r_addr, mem_d_w_addr, mem_d_w_data, mem_d_we,
           load_start, load_valid, load_data, load_last, out_ready,
    output mem_i_r_data, mem_d_r_data, soft_reset, load_ready, out_valid, out_data
  );

  modport master (
    output mem_i_r_addr, mem_d_r_addr, mem_d_w_addr, mem_d_w_data, mem_d_we,
           load_start, load_valid, load_data, load_last, out_ready,
    input  mem_i_r_data, mem_d_r_data, soft_reset, load_ready, out_valid, out_data
  );
endinterface

// File: rtl/mini16sc_out_fifo.sv
// Synchronous FIFO with occupancy count; a push on a full FIFO is accepted
// only when a pop happens in the same cycle.
module mini16sc_out_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Storage is reset so the stream data output is defined from reset on.
  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wr_ptr, rd_ptr;
  logic                        do_push, do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/mini16sc_mem_responder.sv
// Memory-side responder for mini16sc: instruction/data RAMs, host image
// loader that holds the CPU in soft_reset, and an IO-mapped output stream.
module mini16sc_mem_responder
  import mini16sc_mem_pkg::*;
#(
  parameter int WIDTH_I    = 16,
  parameter int WIDTH_D    = 16,
  parameter int DEPTH_I    = 8,
  parameter int DEPTH_D    = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  mini16sc_mem_if.slave   bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [DEPTH_D-1:0] IO_TX   = DEPTH_D'(io_tx_off(DEPTH_D));
  localparam logic [DEPTH_D-1:0] IO_STAT = DEPTH_D'(io_stat_off(DEPTH_D));

  state_t             state, state_nxt;
  logic [DEPTH_I-1:0] load_addr;
  logic               ovf;
  logic [WIDTH_I-1:0] imem [2**DEPTH_I];
  logic [WIDTH_D-1:0] dmem [2**DEPTH_D];
  logic               cpu_we, is_tx, is_stat, load_fire;
  logic               fifo_full, fifo_empty, pop;
  logic [CW-1:0]      fifo_count;
  logic [WIDTH_D-1:0] stat_word;

  // CPU strobes are masked while it is held so a stray store cannot land.
  assign cpu_we    = bus.mem_d_we && (state == S_RUN);
  assign is_tx     = (bus.mem_d_w_addr == IO_TX);
  assign is_stat   = (bus.mem_d_w_addr == IO_STAT);
  assign load_fire = (state == S_LOAD) && bus.load_valid;
  assign pop       = !fifo_empty && bus.out_ready;
  assign bus.out_valid = !fifo_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    bus.soft_reset = 1'b0;
    bus.load_ready = 1'b0;
    unique case (state)
      S_RUN:     if (bus.load_start) state_nxt = S_LOAD;
      S_LOAD: begin
        bus.soft_reset = 1'b1;
        bus.load_ready = 1'b1;
        if (bus.load_valid && bus.load_last) state_nxt = S_RELEASE;
      end
      S_RELEASE: begin
        bus.soft_reset = 1'b1;
        state_nxt      = S_RUN;
      end
      default:   state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                     load_addr <= '0;
    else if ((state == S_RUN) && bus.load_start)   load_addr <= '0;
    else if (load_fire)                            load_addr <= load_addr + DEPTH_I'(1);
  end

  always_ff @(posedge clk) begin
    if (load_fire) imem[load_addr] <= bus.load_data;
  end

  always_ff @(posedge clk) begin
    if (cpu_we && !is_tx && !is_stat) dmem[bus.mem_d_w_addr] <= bus.mem_d_w_data;
  end

  // A full-FIFO push only drops when no pop frees a slot in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                             ovf <= 1'b0;
    else if (cpu_we && is_tx && fifo_full && !pop)         ovf <= 1'b1;
    else if (cpu_we && is_stat && bus.mem_d_w_data[STAT_OVF]) ovf <= 1'b0;
  end

  always_comb begin
    stat_word            = '0;
    stat_word[STAT_OVF]  = ovf;
    stat_word[STAT_FULL] = fifo_full;
    stat_word[CW-1:0]    = fifo_count;
  end

  // Registered reads sample the array before this edge's write: read-before-write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.mem_i_r_data <= '0;
      bus.mem_d_r_data <= '0;
    end else begin
      bus.mem_i_r_data <= imem[bus.mem_i_r_addr];
      if (bus.mem_d_r_addr == IO_STAT)
        bus.mem_d_r_data <= (state == S_LOAD) ? '0 : stat_word;
      else if (bus.mem_d_r_addr == IO_TX)
        bus.mem_d_r_data <= '0;
      else
        bus.mem_d_r_data <= dmem[bus.mem_d_r_addr];
    end
  end

  mini16sc_out_fifo #(.WIDTH(WIDTH_D), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (cpu_we && is_tx),
    .push_data (bus.mem_d_w_data),
    .pop       (pop),
    .pop_data  (bus.out_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );
endmodule

// File: tb/tb_mini16sc_mem_responder.sv
// Directed bench for mini16sc_mem_responder with a queue/array reference model
// checked every cycle plus hand-computed literal checks.
module tb_mini16sc_mem_responder;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  mini16sc_mem_if bus ();

  mini16sc_mem_responder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: RAMs with known-bits, stream as a queue, mode 0/1/2 = run/load/release.
  logic [15:0] imem_m [256];
  logic [15:0] dmem_m [256];
  bit          ik [256];
  bit          dk [256];
  logic [15:0] q [$];
  bit          ovf_m;
  int          mode_m;
  logic [7:0]  la_m;
  logic [15:0] e_i, e_d;
  bit          e_i_k, e_d_k;

  always @(posedge clk or posedge reset) begin
    int          om;
    bit          popped;
    logic [15:0] stat;
    if (reset) begin
      q.delete();
      ovf_m = 0; mode_m = 0; la_m = 0;
      e_i = 0; e_d = 0; e_i_k = 1; e_d_k = 1;
    end else begin
      om     = mode_m;
      popped = (q.size() > 0) && bus.out_ready;
      stat   = {ovf_m, (q.size() == 4), 11'd0, 3'(q.size())};
      e_i    = imem_m[bus.mem_i_r_addr];
      e_i_k  = ik[bus.mem_i_r_addr];
      if (bus.mem_d_r_addr == 8'hFF) begin
        e_d = 0; e_d_k = 1;
      end else if (bus.mem_d_r_addr == 8'hFE) begin
        e_d = (om == 1) ? 16'h0 : stat; e_d_k = 1;
      end else begin
        e_d = dmem_m[bus.mem_d_r_addr]; e_d_k = dk[bus.mem_d_r_addr];
      end
      if (popped) void'(q.pop_front());
      if (om == 0 && bus.mem_d_we) begin
        if (bus.mem_d_w_addr == 8'hFF) begin
          if (q.size() < 4) q.push_back(bus.mem_d_w_data);
          else ovf_m = 1;
        end else if (bus.mem_d_w_addr == 8'hFE) begin
          if (bus.mem_d_w_data[15]) ovf_m = 0;
        end else begin
          dmem_m[bus.mem_d_w_addr] = bus.mem_d_w_data;
          dk[bus.mem_d_w_addr] = 1;
        end
      end
      case (om)
        0: if (bus.load_start) begin mode_m = 1; la_m = 0; end
        1: if (bus.load_valid) begin
             imem_m[la_m] = bus.load_data; ik[la_m] = 1;
             la_m = la_m + 8'd1;
             if (bus.load_last) mode_m = 2;
           end
        default: mode_m = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (e_i_k) chk("m_i_r_data", bus.mem_i_r_data, e_i);
      if (e_d_k) chk("m_d_r_data", bus.mem_d_r_data, e_d);
      chk("m_soft_reset", bus.soft_reset, mode_m != 0);
      chk("m_load_ready", bus.load_ready, mode_m == 1);
      chk("m_out_valid", bus.out_valid, q.size() > 0);
      if (q.size() > 0) chk("m_out_data", bus.out_data, q[0]);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic store(input logic [7:0] a, input logic [15:0] d);
    bus.mem_d_we = 1; bus.mem_d_w_addr = a; bus.mem_d_w_data = d;
    tick();
    bus.mem_d_we = 0;
  endtask

  task automatic read_d(input logic [7:0] a, input logic [15:0] exp, input string name);
    bus.mem_d_r_addr = a;
    tick();
    chk(name, bus.mem_d_r_data, exp);
  endtask

  task automatic fetch(input logic [7:0] a, input logic [15:0] exp, input string name);
    bus.mem_i_r_addr = a;
    tick();
    chk(name, bus.mem_i_r_data, exp);
  endtask

  task automatic load_word(input logic [15:0] d, input logic last);
    bus.load_valid = 1; bus.load_data = d; bus.load_last = last;
    tick();
    bus.load_valid = 0; bus.load_last = 0;
  endtask

  initial begin
    logic [15:0] seq [4];
    seq = '{16'd2, 16'd3, 16'd4, 16'd9};
    reset = 1;
    bus.mem_i_r_addr = 0; bus.mem_d_r_addr = 0; bus.mem_d_w_addr = 0;
    bus.mem_d_w_data = 0; bus.mem_d_we = 0; bus.load_start = 0;
    bus.load_valid = 0; bus.load_data = 0; bus.load_last = 0; bus.out_ready = 0;
    tick(); tick();
    chk("rst_i_r_data", bus.mem_i_r_data, 0);
    chk("rst_d_r_data", bus.mem_d_r_data, 0);
    chk("rst_soft_reset", bus.soft_reset, 0);
    chk("rst_load_ready", bus.load_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    reset = 0;
    tick();

    // data RAM latency and read-before-write
    store(8'd5, 16'h1234);
    read_d(8'd5, 16'h1234, "ld5");
    bus.mem_d_we = 1; bus.mem_d_w_addr = 8'd5; bus.mem_d_w_data = 16'hBEEF;
    bus.mem_d_r_addr = 8'd5;
    tick();
    bus.mem_d_we = 0;
    chk("rbw_old", bus.mem_d_r_data, 16'h1234);
    read_d(8'd5, 16'hBEEF, "ld5_new");

    // image load with toggling valid and stray CPU stores
    bus.load_start = 1; tick(); bus.load_start = 0;
    chk("load_sr", bus.soft_reset, 1);
    chk("load_lr", bus.load_ready, 1);
    load_word(16'hA001, 0);
    bus.mem_d_we = 1; bus.mem_d_w_addr = 8'd5; bus.mem_d_w_data = 16'hDEAD;
    tick();
    bus.mem_d_w_addr = 8'hFF;
    tick();
    bus.mem_d_we = 0;
    load_word(16'hA002, 0);
    tick();
    load_word(16'hA003, 1);
    chk("rel_sr", bus.soft_reset, 1);
    chk("rel_lr", bus.load_ready, 0);
    tick();
    chk("run_sr", bus.soft_reset, 0);
    fetch(8'd0, 16'hA001, "imem0");
    fetch(8'd1, 16'hA002, "imem1");
    fetch(8'd2, 16'hA003, "imem2");
    read_d(8'd5, 16'hBEEF, "stray_masked");
    chk("stray_no_push", bus.out_valid, 0);

    // overflow and status word
    for (int i = 1; i <= 5; i++) store(8'hFF, 16'(i));
    read_d(8'hFE, 16'hC004, "stat_full_ovf");
    chk("head_word", bus.out_data, 16'd1);
    store(8'hFE, 16'h8000);
    read_d(8'hFE, 16'h4004, "stat_ovf_clr");

    // push and pop on a full FIFO in the same cycle
    bus.out_ready = 1;
    bus.mem_d_we = 1; bus.mem_d_w_addr = 8'hFF; bus.mem_d_w_data = 16'd9;
    chk("drain0", bus.out_data, 16'd1);
    tick();
    bus.mem_d_we = 0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d", i + 1), bus.out_data, seq[i]);
      tick();
    end
    chk("drained", bus.out_valid, 0);
    bus.out_ready = 0;
    read_d(8'hFE, 16'h0000, "stat_no_ovf");

    // asynchronous reset in the middle of a load
    store(8'hFF, 16'h0077);
    bus.load_start = 1; tick(); bus.load_start = 0;
    load_word(16'h5550, 0);
    load_word(16'h5551, 0);
    #2 reset = 1;
    #1;
    chk("arst_sr", bus.soft_reset, 0);
    chk("arst_lr", bus.load_ready, 0);
    chk("arst_ov", bus.out_valid, 0);
    @(negedge clk); #1 reset = 0;
    fetch(8'd0, 16'h5550, "keep0");
    fetch(8'd1, 16'h5551, "keep1");
    fetch(8'd2, 16'hA003, "keep2");

    // load address wraps after 256 words
    bus.load_start = 1; tick(); bus.load_start = 0;
    for (int i = 0; i < 256; i++) load_word(16'h1000 + 16'(i), 0);
    load_word(16'hF00D, 1);
    chk("wrap_rel_sr", bus.soft_reset, 1);
    chk("wrap_rel_lr", bus.load_ready, 0);
    tick();
    fetch(8'd0, 16'hF00D, "wrap0");
    fetch(8'd1, 16'h1001, "wrap1");
    fetch(8'd255, 16'h10FF, "wrap255");

    tick(); tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mini16sc_mem_responder.md
Name: mini16sc_mem_responder

Overview:
Memory-side responder for the mini16sc CPU bus. It serves the CPU's instruction-fetch port and data load/store ports from internal synchronous RAMs. A host load port writes instruction RAM while holding the CPU in soft_reset. A store to a reserved data address pushes words into an output stream FIFO that drains over a valid/ready handshake.

Parameters:
WIDTH_I, 16, instruction word width
WIDTH_D, 16, data word width
DEPTH_I, 8, instruction address bits (2^DEPTH_I words)
DEPTH_D, 8, data address bits (2^DEPTH_D words)
FIFO_DEPTH, 4, output FIFO entries, power of two, >=2

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
mem_i_r_addr  in  DEPTH_I  CPU fetch address
mem_i_r_data  out  WIDTH_I  fetch data, registered
mem_d_r_addr  in  DEPTH_D  CPU load address
mem_d_r_data  out  WIDTH_D  load data, registered
mem_d_w_addr  in  DEPTH_D  CPU store address
mem_d_w_data  in  WIDTH_D  CPU store data
mem_d_we  in  1  CPU store strobe
soft_reset  out  1  holds the CPU PC at 0
load_start  in  1  host request to enter load mode
load_valid  in  1  host word valid
load_data  in  WIDTH_I  host instruction word
load_last  in  1  marks final word of image
load_ready  out  1  accept qualifier
out_valid  out  1  stream word valid
out_data  out  WIDTH_D  stream word
out_ready  in  1  stream sink ready

Behaviour:
- Single clock domain. reset is asynchronous and active-high. Internal RAM contents are not reset.
- Output values on reset: mem_i_r_data=0, mem_d_r_data=0, soft_reset=0, load_ready=0, out_valid=0, out_data=0; state=S_RUN, load_addr=0, FIFO empty, overflow=0.
- Reads have one-cycle latency. The address sampled at edge k is presented after edge k+1. Both read ports are read-before-write: a same-cycle store to the same address returns the old value.
- Address map:
  - IO_TX = 2^DEPTH_D-1: store-only.
  - IO_STAT = 2^DEPTH_D-2: load-only.
  - All other addresses are plain RAM.
- A store to IO_TX does not write RAM:
  - If the FIFO is not full, mem_d_w_data is pushed.
  - If the FIFO is full, the word is dropped and sticky overflow is set.
- A load from IO_STAT returns {overflow at bit 15, full at bit 14, zeros, count in bits [$clog2(FIFO_DEPTH):0]}. It reads as 0 during S_LOAD.
- A store to IO_STAT writes 1 to bit 15 to clear overflow. It does not write RAM.
- FSM:
  - S_RUN: soft_reset=0, load_ready=0. load_start=1 -> S_LOAD, load_addr<=0.
  - S_LOAD: soft_reset=1, load_ready=1. On load_valid&load_ready, imem[load_addr]<=load_data and load_addr increments, wrapping modulo 2^DEPTH_I. An accepted word with load_last=1 -> S_RELEASE. load_start is ignored in this state.
  - S_RELEASE: soft_reset=1, load_ready=0. Lasts exactly one cycle, then -> S_RUN. The CPU's first fetch after release is address 0.
- CPU stores are ignored (mem_d_we masked) in S_LOAD and S_RELEASE. The CPU is held, but stray strobes must not corrupt RAM or the FIFO.
- FIFO:
  - A push and a pop (out_valid&out_ready) in the same cycle on a full FIFO both succeed; count is unchanged and no overflow is set.
  - A push on an empty FIFO appears on out_valid the next cycle; first-word fall-through is not required.
  - out_data is stable while out_valid=1 and out_ready=0.
- Reset asserted mid-load returns to S_RUN with soft_reset=0. Words already written stay in imem; load_addr is 0.

Decomposition:
- Package mini16sc_mem_pkg holds:
  - the state encoding (S_RUN, S_LOAD, S_RELEASE);
  - the IO_TX/IO_STAT offset helpers;
  - STAT bit positions (STAT_OVF=15, STAT_FULL=14).
- Sub-module mini16sc_out_fifo: parameterised width/depth synchronous FIFO with push, pop, full, empty and count. The RAMs and FSM stay in the top module.

Test Plan:
- Store 0x1234 to data addr 5, then load addr 5 -> mem_d_r_data=0x1234 exactly one cycle after the address is sampled. A store of 0xBEEF and a load of addr 5 in the same cycle -> read returns 0x1234.
- load_start, then 3 words 0xA001, 0xA002, 0xA003, last on the third, with load_valid toggling -> soft_reset high from the cycle after load_start through S_RELEASE. imem[0..2] hold the words; fetches of addrs 0..2 return them.
- With out_ready=0, store 1..5 to 0xFF (DEPTH_D=8) -> FIFO holds 1..4 and overflow=1. Load 0xFE -> 0xC004. Store 0x8000 to 0xFE -> overflow=0.
- Full FIFO, out_ready=1 and a store of 9 to 0xFF in the same cycle -> out_data sequence 1,2,3,4,9; overflow stays 0.
- Assert reset asynchronously mid-load after 2 words -> soft_reset, load_ready and out_valid go 0 immediately; state is S_RUN; imem[0..1] are retained.
- Load 256 words (DEPTH_I=8) without last, then one more word with last -> that word is written to imem[0] (wrap), then release.
